// File: rtl/spike_rate_decoder_if.sv
// Result port of the spike rate decoder: {rate, isi} offered on a valid/ready handshake.
interface spike_rate_decoder_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rate_out;
    logic [7:0] isi_out;

    modport master (output out_valid, output rate_out, output isi_out, input  out_ready);
    modport slave  (input  out_valid, input  rate_out, input  isi_out, output out_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// Turns a spike train back into numbers: spike edges per programmable window of enabled
// cycles plus the most recent inter-spike interval, delivered on a valid/ready result port.
module spike_rate_decoder (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          spike_in,
    input  logic [7:0]                    window_len,
    spike_rate_decoder_if.master          res,
    output logic                          overrun
);

    logic       spike_prev;
    logic [7:0] win_cnt;
    logic [7:0] spk_cnt;
    logic [7:0] isi_cnt;
    logic [7:0] isi_last;

    logic       spk_edge;
    logic       win_end;
    logic [7:0] win_last;
    logic [7:0] isi_cnt_nxt;
    logic [7:0] isi_last_nxt;
    logic [7:0] rate_res;

    // window_len - 1 wraps to 255 when window_len is 0, giving a 256-cycle window.
    assign win_last = window_len - 8'd1;
    assign spk_edge = enable & spike_in & ~spike_prev;
    assign win_end  = enable & (win_cnt == win_last);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        isi_cnt_nxt  = isi_cnt;
        isi_last_nxt = isi_last;
        if (enable) begin
            if (spk_edge) begin
                isi_last_nxt = isi_cnt;
                isi_cnt_nxt  = 8'd1;
            end else if (isi_cnt != 8'hFF) begin
                isi_cnt_nxt  = isi_cnt + 8'd1;
            end
        end
    end

    // The closing cycle's own edge is part of the result; at most 128 edges fit in 256 cycles.
    assign rate_res = spk_cnt + {7'd0, spk_edge};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            // NOTE: reset is synchronous; everything here is a plain register, so all of it is cleared.
            spike_prev    <= 1'b0;
            win_cnt       <= 8'd0;
            spk_cnt       <= 8'd0;
            isi_cnt       <= 8'd0;
            isi_last      <= 8'd0;
            res.out_valid <= 1'b0;
            res.rate_out  <= 8'd0;
            res.isi_out   <= 8'd0;
            overrun       <= 1'b0;
        end else begin
            isi_cnt  <= isi_cnt_nxt;
            isi_last <= isi_last_nxt;
            if (enable) begin
                spike_prev <= spike_in;
                if (win_end) begin
                    win_cnt <= 8'd0;
                    spk_cnt <= 8'd0;
                end else begin
                    win_cnt <= win_cnt + 8'd1;
                    spk_cnt <= rate_res;
                end
            end

            // A result arriving while the previous one is still unaccepted is dropped, not queued.
            if (win_end) begin
                if (!res.out_valid || res.out_ready) begin
                    res.out_valid <= 1'b1;
                    res.rate_out  <= rate_res;
                    res.isi_out   <= isi_last_nxt;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (res.out_valid && res.out_ready) begin
                res.out_valid <= 1'b0;
            end
        end
    end

endmodule
